fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: Width, 32, instruction and address width in bits.
REQ-002 Parameter: ResetVector, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 run  input  1  1 = fetch enabled; 0 = stop issuing fetches.
REQ-006 redirect_valid  input  1  branch/jump target present this cycle.
REQ-007 redirect_pc  input  Width  new fetch address.
REQ-008 imem_address  output  Width  byte address to instruction memory.
REQ-009 imem_valid  output  1  fetch request; memory returns imem_data in the same cycle.
REQ-010 imem_data  input  Width  instruction word from memory, combinational.
REQ-011 instr_valid  output  1  buffered instruction available to decode.
REQ-012 instr_ready  input  1  decode accepts the head entry.
REQ-013 instr  output  Width  head instruction word.
REQ-014 instr_pc  output  Width  byte address of the head instruction.

Function
REQ-015 FSM states: IDLE (no fetch) and FETCH; IDLE->FETCH when run=1; FETCH->IDLE when run=0; the transition takes effect on the next edge.
REQ-016 A fetch is issued (imem_valid=1) only when state=FETCH, redirect_valid=0 and buffer count<2; otherwise imem_valid=0.
REQ-017 imem_address equals pc every cycle; pc is aligned with bits [1:0] always 0.
REQ-018 On an issued fetch, {pc, imem_data} is written to the buffer tail and pc becomes pc+4 modulo 2^Width (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-019 The buffer is a 2-entry in-order FIFO; instr_valid=1 iff count>0 and redirect_valid=0; instr/instr_pc show the head entry.
REQ-020 A pop occurs when instr_valid and instr_ready are both 1; push and pop in the same cycle leave count unchanged and preserve order.
REQ-021 Sustained instr_ready=1 with run=1 yields one instruction per cycle after a 1-cycle fill latency (fetch in cycle N, instr_valid in cycle N+1).
REQ-022 instr/instr_pc remain stable while instr_valid=1 and instr_ready=0.
REQ-023 When redirect_valid=1: no pop, no push, buffer is flushed to count=0, and pc <= {redirect_pc[Width-1:2], 2'b00}; this applies in both IDLE and FETCH.
REQ-024 When run falls, entries already buffered still drain normally.
REQ-025 When count=2 and a pop occurs, no fetch is issued that cycle; fetching resumes the next cycle.

Reset
REQ-026 While rst_n=0: state=IDLE, pc=ResetVector, count=0, imem_valid=0, instr_valid=0, instr=0, instr_pc=0.
REQ-027 Reset asserted mid-operation discards buffered entries immediately; the first fetch after release is at ResetVector, and only once run=1.

Structure
REQ-028 Shared package fetch_pkg holds the FSM state enum (IDLE, FETCH), the buffer entry struct {pc, instr}, and the instruction-size constant (4 bytes).
REQ-029 The FIFO is a sub-module fetch_buffer (depth 2, push/pop/flush, count output); the FSM and pc register stay in fetch_unit.
REQ-030 No combinational path from instr_ready to imem_valid other than through count.

Verification
REQ-031 Reset, run=1, instr_ready=1, memory words 0x00000013 at addresses 0x0..0xC -> instr_pc 0x0, 0x4, 0x8, 0xC on consecutive cycles starting one cycle after the first fetch.
REQ-032 instr_ready=0 for 5 cycles -> exactly 2 fetches (0x0, 0x4), imem_valid=0 afterwards, instr_pc held at 0x0; ready=1 -> 0x0, 0x4, 0x8 in order, with no loss or duplicate.
REQ-033 redirect_valid=1 with redirect_pc=0x103 while count=2 -> instr_valid=0 that cycle, buffer flushed, next fetch address 0x100.
REQ-034 redirect to 0xFFFF_FFFC, run=1 -> fetches at 0xFFFF_FFFC and then 0x0000_0000.
REQ-035 run dropped with 2 entries buffered -> no new imem_valid, both entries drain, state=IDLE.
REQ-036 rst_n pulsed low mid-stream -> outputs zero asynchronously; after release with run=1, the first instr_pc is ResetVector.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry in-order FIFO of fetched {pc, instr} pairs with single-cycle flush.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     push_entry,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage, pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: IDLE/FETCH control, pc register and a 2-deep decode buffer.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      Width       = XLEN,
  parameter logic [Width-1:0] ResetVector = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic [Width-1:0] imem_address,
  output logic             imem_valid,
  input  logic [Width-1:0] imem_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [Width-1:0] instr,
  output logic [Width-1:0] instr_pc
);

  state_e           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic [1:0]       count_s;
  logic             fetch_s;
  logic             pop_s;
  entry_t           push_entry_s;
  entry_t           head_s;
  logic             unused_redirect_lsb;

  assign unused_redirect_lsb = &{1'b0, redirect_pc[1:0]};

  // Fetch depends on count only, so instr_ready never reaches imem_valid directly.
  assign fetch_s      = (state_q == FETCH) && !redirect_valid && (count_s < 2'd2);
  assign instr_valid  = (count_s != 2'd0) && !redirect_valid;
  assign pop_s        = instr_valid && instr_ready;
  assign push_entry_s = '{pc: pc_q, instr: imem_data};

  // Run/stop state transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? FETCH : IDLE;
      FETCH:   state_d = run ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Program counter: redirect target (word aligned), else advance on a fetch.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = {redirect_pc[Width-1:2], 2'b00};
    end else if (fetch_s) begin
      pc_d = pc_q + Width'(INSTR_BYTES);
    end else begin
      pc_d = pc_q;
    end
  end

  // Control state and pc registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= ResetVector;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch_s),
    .pop        (pop_s),
    .flush      (redirect_valid),
    .push_entry (push_entry_s),
    .head       (head_s),
    .count      (count_s)
  );

  assign imem_address = pc_q;
  assign imem_valid   = fetch_s;
  assign instr        = head_s.instr;
  assign instr_pc     = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit against a simple memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_address;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        pattern_mode;

  int n_checks;
  int n_errors;
  logic [31:0] fetch_q[$];

  fetch_unit #(.Width(32), .ResetVector(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run            (run),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_address   (imem_address),
    .imem_valid     (imem_valid),
    .imem_data      (imem_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // Memory: constant NOP words, or address-tagged words to expose ordering errors.
  assign imem_data = pattern_mode ? (imem_address ^ 32'hCAFE_0000) : 32'h0000_0013;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst_n          = 1'b0;
    run            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;
    pattern_mode   = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check_eq("rst_imem_valid", {31'd0, imem_valid}, 32'd0);
    check_eq("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_pc", instr_pc, 32'h0);
    check_eq("rst_address", imem_address, 32'h0);

    // Streaming: one instruction per cycle after a single fill cycle
    cyc();
    rst_n = 1'b1; run = 1'b1; instr_ready = 1'b1;
    #1;
    check_eq("stream_idle_no_fetch", {31'd0, imem_valid}, 32'd0);
    cyc(); #1;
    check_eq("stream_first_fetch", {31'd0, imem_valid}, 32'd1);
    check_eq("stream_first_addr", imem_address, 32'h0);
    check_eq("stream_fill_empty", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(); #1;
      check_eq("stream_valid", {31'd0, instr_valid}, 32'd1);
      check_eq("stream_pc", instr_pc, 32'(k * 4));
      check_eq("stream_instr", instr, 32'h0000_0013);
    end

    // Back-pressure: buffer fills at two entries then holds
    rst_n = 1'b0; run = 1'b0; instr_ready = 1'b0; pattern_mode = 1'b1;
    cyc();
    rst_n = 1'b1; run = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (imem_valid) fetch_q.push_back(imem_address);
      cyc();
    end
    #1;
    check_eq("bp_fetch_count", fetch_q.size(), 32'd2);
    if (fetch_q.size() == 2) begin
      check_eq("bp_fetch0", fetch_q[0], 32'h0);
      check_eq("bp_fetch1", fetch_q[1], 32'h4);
    end
    check_eq("bp_full_no_fetch", {31'd0, imem_valid}, 32'd0);
    check_eq("bp_hold_pc", instr_pc, 32'h0);
    check_eq("bp_hold_valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    #1;
    check_eq("full_pop_no_fetch", {31'd0, imem_valid}, 32'd0);
    check_eq("drain_pc0", instr_pc, 32'h0);
    check_eq("drain_instr0", instr, 32'hCAFE_0000);
    cyc(); #1;
    check_eq("drain_pc1", instr_pc, 32'h4);
    check_eq("resume_fetch", {31'd0, imem_valid}, 32'd1);
    check_eq("resume_addr", imem_address, 32'h8);
    cyc(); #1;
    check_eq("drain_pc2", instr_pc, 32'h8);
    check_eq("drain_instr2", instr, 32'hCAFE_0008);
    instr_ready = 1'b0;
    cyc(); #1;
    check_eq("refill_head", instr_pc, 32'h8);
    check_eq("refill_full", {31'd0, imem_valid}, 32'd0);

    // Redirect with two entries buffered flushes and realigns the target
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1;
    check_eq("redir_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("redir_no_fetch", {31'd0, imem_valid}, 32'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("redir_flushed", {31'd0, instr_valid}, 32'd0);
    check_eq("redir_addr", imem_address, 32'h0000_0100);
    check_eq("redir_fetch", {31'd0, imem_valid}, 32'd1);
    cyc(); #1;
    check_eq("redir_head_pc", instr_pc, 32'h0000_0100);
    check_eq("redir_head_instr", instr, 32'hCAFE_0100);

    // Address wrap at the top of memory
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    #1;
    check_eq("wrap_addr_hi", imem_address, 32'hFFFF_FFFC);
    check_eq("wrap_fetch_hi", {31'd0, imem_valid}, 32'd1);
    cyc(); #1;
    check_eq("wrap_addr_lo", imem_address, 32'h0000_0000);
    check_eq("wrap_fetch_lo", {31'd0, imem_valid}, 32'd1);
    check_eq("wrap_head_pc", instr_pc, 32'hFFFF_FFFC);

    // Stop with two entries buffered: no new fetches, both entries drain
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    run = 1'b0;
    #1;
    check_eq("stop_full_no_fetch", {31'd0, imem_valid}, 32'd0);
    check_eq("stop_head0", instr_pc, 32'h0000_0200);
    cyc();
    instr_ready = 1'b1;
    #1;
    check_eq("stop_drain_valid0", {31'd0, instr_valid}, 32'd1);
    check_eq("stop_drain_pc0", instr_pc, 32'h0000_0200);
    cyc(); #1;
    check_eq("stop_drain_pc1", instr_pc, 32'h0000_0204);
    check_eq("stop_no_fetch1", {31'd0, imem_valid}, 32'd0);
    cyc(); #1;
    check_eq("stop_empty", {31'd0, instr_valid}, 32'd0);
    check_eq("stop_idle_no_fetch", {31'd0, imem_valid}, 32'd0);
    check_eq("stop_pc_held", imem_address, 32'h0000_0208);

    // Asynchronous reset mid-stream
    run = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_eq("arst_imem_valid", {31'd0, imem_valid}, 32'd0);
    check_eq("arst_instr", instr, 32'h0);
    check_eq("arst_instr_pc", instr_pc, 32'h0);
    check_eq("arst_address", imem_address, 32'h0);
    cyc();
    rst_n = 1'b1;
    #1;
    check_eq("arst_idle", {31'd0, imem_valid}, 32'd0);
    cyc(); #1;
    check_eq("arst_first_fetch", {31'd0, imem_valid}, 32'd1);
    check_eq("arst_first_addr", imem_address, 32'h0);
    cyc(); #1;
    check_eq("arst_first_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("arst_first_pc", instr_pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
